// File: rtl/sigma_delta_adc_pkg.sv
// ---------------------------------------------------------------------------
// sigma_delta_adc_pkg
//   Shared audio constants for the EAR input path. The mixer, the ULA and the
//   sigma-delta ADC all import these defaults so that the decimation ratio and
//   the Schmitt thresholds agree everywhere.
//
//   ADC_OSR_LOG2  log2 of the decimation window (cycles per sample)
//   EAR_HYST_HI   sample >= this sets the ear bit
//   EAR_HYST_LO   sample <= this clears the ear bit
//   ear_next()    Schmitt decision for one new sample
// ---------------------------------------------------------------------------
package sigma_delta_adc_pkg;

  localparam int unsigned ADC_OSR_LOG2 = 10;
  localparam int unsigned EAR_HYST_HI  = 640;
  localparam int unsigned EAR_HYST_LO  = 384;

  // Samples strictly between the thresholds keep the previous ear level.
  function automatic logic ear_next(input int unsigned smp,
                                    input logic        cur,
                                    input int unsigned hi,
                                    input int unsigned lo);
    if (smp >= hi) begin
      return 1'b1;
    end
    if (smp <= lo) begin
      return 1'b0;
    end
    return cur;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Generic 1-bit two-flop synchronizer for asynchronous input pins.
//   Both stages clear to 0 on a synchronous active-high reset.
//
//   i_clk    destination clock
//   i_reset  synchronous, active-high
//   i_d      asynchronous input
//   o_q      synchronized output (two edges of latency)
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/sigma_delta_adc.sv
// ---------------------------------------------------------------------------
// sigma_delta_adc
//   First-order sigma-delta ADC for the EAR (tape/line) input. An external RC
//   integrator and comparator close the loop through o_fb_out. The 1-bit
//   stream is decimated over 2^OSR_LOG2 cycles into an unsigned sample, and a
//   hysteretic ear bit is derived from each new sample for the ULA port.
//
//   i_clkdac        oversampling clock (shared with the audio DAC)
//   i_reset         synchronous, active-high
//   i_en            1 = decimator running, 0 = window held cleared
//   i_cmp_in        asynchronous comparator output
//   o_fb_out        feedback bit to the RC integrator (registered)
//   o_sample        last decimated sample, 0 .. 2^OSR_LOG2-1
//   o_sample_valid  one-cycle pulse, o_sample updated in the same cycle
//   o_clip          last window was all-0 or all-1
//   o_ear           Schmitt-thresholded sample
// ---------------------------------------------------------------------------
module sigma_delta_adc
  import sigma_delta_adc_pkg::*;
#(
  parameter int unsigned OSR_LOG2 = ADC_OSR_LOG2,
  parameter int unsigned HYST_HI  = EAR_HYST_HI,
  parameter int unsigned HYST_LO  = EAR_HYST_LO
) (
  input  logic                i_clkdac,
  input  logic                i_reset,
  input  logic                i_en,
  input  logic                i_cmp_in,
  output logic                o_fb_out,
  output logic [OSR_LOG2-1:0] o_sample,
  output logic                o_sample_valid,
  output logic                o_clip,
  output logic                o_ear
);

  logic                w_s2;
  logic                r_fb;
  logic [OSR_LOG2-1:0] r_win_cnt;
  logic [OSR_LOG2:0]   r_acc;
  logic [OSR_LOG2-1:0] r_sample;
  logic                r_valid;
  logic                r_clip;
  logic                r_ear;

  logic [OSR_LOG2:0]   w_sum;
  logic                w_win_end;
  logic                w_sum_full;
  logic                w_sum_zero;

  sync_2ff u_sync (
    .i_clk   (i_clkdac),
    .i_reset (i_reset),
    .i_d     (i_cmp_in),
    .o_q     (w_s2)
  );

  // The decimator integrates the bit actually driven onto the pin, so the
  // digital count matches the charge delivered to the integrator.
  assign w_sum      = r_acc + (OSR_LOG2 + 1)'(r_fb);
  assign w_win_end  = (r_win_cnt == {OSR_LOG2{1'b1}});
  // Sum never exceeds 2^N, so the top bit alone marks the all-ones window.
  assign w_sum_full = w_sum[OSR_LOG2];
  assign w_sum_zero = (w_sum == '0);

  always_ff @(posedge i_clkdac) begin
    if (i_reset) begin
      r_fb      <= 1'b0;
      r_win_cnt <= '0;
      r_acc     <= '0;
      r_sample  <= '0;
      r_valid   <= 1'b0;
      r_clip    <= 1'b0;
    end else begin
      r_fb    <= w_s2;
      r_valid <= 1'b0;
      if (i_en) begin
        if (w_win_end) begin
          r_sample  <= w_sum_full ? {OSR_LOG2{1'b1}} : w_sum[OSR_LOG2-1:0];
          r_clip    <= w_sum_zero | w_sum_full;
          r_valid   <= 1'b1;
          r_acc     <= '0;
          r_win_cnt <= '0;
        end else begin
          r_acc     <= w_sum;
          r_win_cnt <= r_win_cnt + OSR_LOG2'(1);
        end
      end else begin
        r_acc     <= '0;
        r_win_cnt <= '0;
      end
    end
  end

  // Ear follows the valid pulse by one edge, using the freshly latched sample.
  always_ff @(posedge i_clkdac) begin
    if (i_reset) begin
      r_ear <= 1'b0;
    end else if (r_valid) begin
      r_ear <= ear_next(32'(r_sample), r_ear, HYST_HI, HYST_LO);
    end
  end

  assign o_fb_out       = r_fb;
  assign o_sample       = r_sample;
  assign o_sample_valid = r_valid;
  assign o_clip         = r_clip;
  assign o_ear          = r_ear;

endmodule

// File: tb/tb_sigma_delta_adc.sv
module tb_sigma_delta_adc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16-cycle window instance, thresholds scaled to the 4-bit range
  logic       rst4, en4, cmp4;
  logic       fb4, valid4, clip4, ear4;
  logic [3:0] smp4;

  // full-size instance for the 640/384 hysteresis sequence
  logic       rst10, en10, cmp10;
  logic       fb10, valid10, clip10, ear10;
  logic [9:0] smp10;

  sigma_delta_adc #(.OSR_LOG2(4), .HYST_HI(12), .HYST_LO(4)) u_dut4 (
    .i_clkdac       (clk),
    .i_reset        (rst4),
    .i_en           (en4),
    .i_cmp_in       (cmp4),
    .o_fb_out       (fb4),
    .o_sample       (smp4),
    .o_sample_valid (valid4),
    .o_clip         (clip4),
    .o_ear          (ear4)
  );

  sigma_delta_adc #(.OSR_LOG2(10), .HYST_HI(640), .HYST_LO(384)) u_dut10 (
    .i_clkdac       (clk),
    .i_reset        (rst10),
    .i_en           (en10),
    .i_cmp_in       (cmp10),
    .o_fb_out       (fb10),
    .o_sample       (smp10),
    .o_sample_valid (valid10),
    .o_clip         (clip10),
    .o_ear          (ear10)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ph    = 0;

  typedef struct {
    logic [15:0] pat;
    int          exp_smp;
    int          exp_clip;
    int          exp_ear;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Periodic pattern: any 16 consecutive feedback bits have the same popcount.
  task automatic tick_pat(input logic [15:0] pat);
    cmp4 = pat[ph];
    ph   = (ph + 1) % 16;
    tick();
  endtask

  // cmp4 is 1 on window ticks 1..hi; stops at the valid pulse or a 40-tick bound.
  task automatic drive_win(input int hi, input string name,
                           input int exp_smp, input int exp_clip);
    int k    = 0;
    bit seen = 1'b0;
    while (!seen && k < 40) begin
      k++;
      cmp4 = (k <= hi);
      tick();
      seen = valid4;
    end
    chk({name, "_len"}, k, 16);
    chk({name, "_sample"}, int'(smp4), exp_smp);
    chk({name, "_clip"}, int'(clip4), exp_clip);
  endtask

  initial begin
    int cnt10[4];
    int ear10_exp[4];
    int vcount;

    rst4 = 1'b1; en4 = 1'b0; cmp4 = 1'b1;
    rst10 = 1'b1; en10 = 1'b0; cmp10 = 1'b0;

    vecs[0] = '{16'h0000,  0, 1, 0};
    vecs[1] = '{16'hFFFF, 15, 1, 1};
    vecs[2] = '{16'hAAAA,  8, 0, 1};
    vecs[3] = '{16'h0001,  1, 0, 0};
    vecs[4] = '{16'h7FFF, 15, 0, 1};
    vecs[5] = '{16'h00FF,  8, 0, 1};
    vecs[6] = '{16'h0007,  3, 0, 0};
    vecs[7] = '{16'hF0F0,  8, 0, 0};

    // reset held with comparator high
    repeat (5) tick();
    chk("rst_fb", int'(fb4), 0);
    chk("rst_sample", int'(smp4), 0);
    chk("rst_valid", int'(valid4), 0);
    chk("rst_clip", int'(clip4), 0);
    chk("rst_ear", int'(ear4), 0);

    rst4 = 1'b0;
    tick(); chk("lat_edge1_fb", int'(fb4), 0);
    tick(); chk("lat_edge2_fb", int'(fb4), 0);
    tick(); chk("lat_edge3_fb", int'(fb4), 1);

    // constant high: saturated sample, valid every 16 edges
    en4 = 1'b1;
    drive_win(40, "first_win", 15, 1);
    drive_win(40, "ones_win2", 15, 1);
    drive_win(40, "ones_win3", 15, 1);

    // table: first window mixes old/new pattern, second is checked
    for (int i = 0; i < 8; i++) begin
      repeat (16) tick_pat(vecs[i].pat);
      tick_pat(vecs[i].pat);
      chk($sformatf("vec%0d_valid_pulse_end", i), int'(valid4), 0);
      repeat (14) tick_pat(vecs[i].pat);
      chk($sformatf("vec%0d_valid_early", i), int'(valid4), 0);
      tick_pat(vecs[i].pat);
      chk($sformatf("vec%0d_valid", i), int'(valid4), 1);
      chk($sformatf("vec%0d_sample", i), int'(smp4), vecs[i].exp_smp);
      chk($sformatf("vec%0d_clip", i), int'(clip4), vecs[i].exp_clip);
      repeat (16) tick_pat(vecs[i].pat);
      chk($sformatf("vec%0d_ear", i), int'(ear4), vecs[i].exp_ear);
    end

    // enable dropped at win_cnt=7 for 20 edges
    for (int k = 0; k < 7; k++) begin
      cmp4 = 1'b1;
      tick();
    end
    en4 = 1'b0; cmp4 = 1'b0;
    vcount = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (valid4) vcount++;
    end
    chk("en_low_valids", vcount, 0);
    chk("en_low_sample_hold", int'(smp4), 8);
    chk("en_low_clip_hold", int'(clip4), 0);
    chk("en_low_ear_hold", int'(ear4), 0);
    en4 = 1'b1;
    drive_win(5, "reenable_win", 5, 0);

    // set ear high, then leave the feedback at 0 for the next window start
    drive_win(16, "prep_a", 13, 0);
    drive_win(13, "prep_b", 15, 1);
    chk("prep_ear", int'(ear4), 1);

    // reset mid-window with win_cnt=10, acc=5
    for (int k = 1; k <= 10; k++) begin
      cmp4 = (k <= 5);
      tick();
    end
    chk("pre_rst_ear", int'(ear4), 1);
    rst4 = 1'b1; cmp4 = 1'b0;
    repeat (2) tick();
    chk("midrst_sample", int'(smp4), 0);
    chk("midrst_clip", int'(clip4), 0);
    chk("midrst_ear", int'(ear4), 0);
    chk("midrst_valid", int'(valid4), 0);
    chk("midrst_fb", int'(fb4), 0);
    rst4 = 1'b0;
    drive_win(2, "post_rst_win", 2, 0);

    // full-size instance: sample sequence 700,500,300,500
    cnt10     = '{700, 500, 300, 500};
    ear10_exp = '{1, 1, 0, 0};
    rst10 = 1'b0; en10 = 1'b1;
    for (int w = 0; w < 4; w++) begin
      for (int j = 0; j < 1024; j++) begin
        cmp10 = (j >= 100) && (j < 100 + cnt10[w]);
        tick();
        if (j == 0 && w > 0) begin
          chk($sformatf("osr10_w%0d_ear_after", w - 1), int'(ear10), ear10_exp[w - 1]);
          chk($sformatf("osr10_w%0d_valid_end", w - 1), int'(valid10), 0);
        end
        if (j == 1023) begin
          chk($sformatf("osr10_w%0d_valid", w), int'(valid10), 1);
          chk($sformatf("osr10_w%0d_sample", w), int'(smp10), cnt10[w]);
          chk($sformatf("osr10_w%0d_clip", w), int'(clip10), 0);
          chk($sformatf("osr10_w%0d_ear_at_valid", w), int'(ear10),
              (w == 0) ? 0 : ear10_exp[w - 1]);
        end
      end
    end
    cmp10 = 1'b0;
    tick();
    chk("osr10_w3_ear_after", int'(ear10), ear10_exp[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
